// File: rtl/reg_bus_pkg.sv
// Shared types for the register-bus arbiter: FSM encoding, owner ids and
// the per-master request record.
package reg_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic OWN_FW = 1'b0;
    localparam logic OWN_UA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

    // Single pending master wins; on a tie the master not granted last wins.
    function automatic logic arb_pick(input logic fw_pend, input logic ua_pend,
                                      input logic last);
        if (fw_pend && ua_pend)
            return ~last;
        return ua_pend ? OWN_UA : OWN_FW;
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_req_hold.sv
// One-deep request holding register for one bus master, with pending flag
// and sticky overflow for strobes that arrive while a request is queued.
module reg_req_hold
    import reg_bus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [7:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_take,
    output logic        o_pend,
    output logic        o_ovf,
    output req_t        o_req
);

    logic r_pend;
    logic r_ovf;
    req_t r_req;

    // The slot frees in the grant cycle, so a strobe landing then is kept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
            r_ovf  <= 1'b0;
            r_req  <= '0;
        end else begin
            if (i_req && (!r_pend || i_take)) begin
                r_req.wr    <= i_wr;
                r_req.addr  <= i_addr;
                r_req.wdata <= i_wdata;
                r_pend      <= 1'b1;
            end else if (i_take) begin
                r_pend <= 1'b0;
            end
            if (i_req && r_pend && !i_take)
                r_ovf <= 1'b1;
        end
    end

    assign o_pend = r_pend;
    assign o_ovf  = r_ovf;
    assign o_req  = r_req;

endmodule

// File: rtl/reg_bus_arbiter.sv
// Two-master register bus arbiter (1394 link and UART debug) with a fixed
// read-mux latency and a one-cycle completion acknowledge per master.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        fw_req,
    input  logic        fw_wr,
    input  logic [7:0]  fw_addr,
    input  logic [31:0] fw_wdata,
    output logic        fw_ack,
    output logic [31:0] fw_rdata,
    output logic        fw_ovf,
    input  logic        ua_req,
    input  logic        ua_wr,
    input  logic [7:0]  ua_addr,
    input  logic [31:0] ua_wdata,
    output logic        ua_ack,
    output logic [31:0] ua_rdata,
    output logic        ua_ovf,
    output logic [7:0]  reg_addr,
    output logic [31:0] reg_wdata,
    output logic        reg_wen,
    input  logic [31:0] reg_rdata,
    output logic        owner,
    output logic        busy
);

    localparam logic [3:0] LAT_M1 = 4'(RD_LAT - 1);

    logic        w_fw_pend, w_ua_pend;
    logic        w_fw_take, w_ua_take;
    req_t        w_fw_hreq, w_ua_hreq, w_sel;
    logic        w_win, w_grant, w_to_done;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last;
    logic        r_owner;
    logic        r_busy;
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_wen;
    logic        r_fw_ack, r_ua_ack;
    logic [31:0] r_fw_rdata, r_ua_rdata;

    reg_req_hold u_fw_hold (
        .i_clk   (sysclk),
        .i_rst_n (reset),
        .i_req   (fw_req),
        .i_wr    (fw_wr),
        .i_addr  (fw_addr),
        .i_wdata (fw_wdata),
        .i_take  (w_fw_take),
        .o_pend  (w_fw_pend),
        .o_ovf   (fw_ovf),
        .o_req   (w_fw_hreq)
    );

    reg_req_hold u_ua_hold (
        .i_clk   (sysclk),
        .i_rst_n (reset),
        .i_req   (ua_req),
        .i_wr    (ua_wr),
        .i_addr  (ua_addr),
        .i_wdata (ua_wdata),
        .i_take  (w_ua_take),
        .o_pend  (w_ua_pend),
        .o_ovf   (ua_ovf),
        .o_req   (w_ua_hreq)
    );

    assign w_win     = arb_pick(w_fw_pend, w_ua_pend, r_last);
    assign w_grant   = (r_state == ST_IDLE) && (w_fw_pend || w_ua_pend);
    assign w_fw_take = w_grant && (w_win == OWN_FW);
    assign w_ua_take = w_grant && (w_win == OWN_UA);
    assign w_sel     = (w_win == OWN_UA) ? w_ua_hreq : w_fw_hreq;
    assign w_to_done = ((r_state == ST_ADDR) && (RD_LAT <= 1)) ||
                       ((r_state == ST_WAIT) && (r_cnt == 4'd1));

    always_ff @(posedge sysclk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_last     <= OWN_UA;
            r_owner    <= OWN_FW;
            r_busy     <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= 8'd0;
            r_wdata    <= 32'd0;
            r_wen      <= 1'b0;
            r_fw_ack   <= 1'b0;
            r_ua_ack   <= 1'b0;
            r_fw_rdata <= 32'd0;
            r_ua_rdata <= 32'd0;
        end else begin
            r_wen    <= 1'b0;
            r_fw_ack <= 1'b0;
            r_ua_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_addr  <= w_sel.addr;
                        r_wdata <= w_sel.wdata;
                        r_wen   <= w_sel.wr;
                        r_wr    <= w_sel.wr;
                        r_owner <= w_win;
                        r_busy  <= 1'b1;
                        // Pointer moves only when a tie is actually resolved.
                        if (w_fw_pend && w_ua_pend)
                            r_last <= w_win;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    r_cnt   <= LAT_M1;
                    r_state <= (RD_LAT > 1) ? ST_WAIT : ST_DONE;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1)
                        r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            // Read data is sampled on the edge into DONE and held until the next ack.
            if (w_to_done) begin
                if (r_owner == OWN_FW) begin
                    r_fw_ack   <= 1'b1;
                    r_fw_rdata <= r_wr ? 32'd0 : reg_rdata;
                end else begin
                    r_ua_ack   <= 1'b1;
                    r_ua_rdata <= r_wr ? 32'd0 : reg_rdata;
                end
            end
        end
    end

    assign fw_ack    = r_fw_ack;
    assign fw_rdata  = r_fw_rdata;
    assign ua_ack    = r_ua_ack;
    assign ua_rdata  = r_ua_rdata;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_wen   = r_wen;
    assign owner     = r_owner;
    assign busy      = r_busy;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: expected acks are queued when a
// strobe is driven and compared when the DUT acknowledges.
module tb_reg_bus_arbiter;

    logic        sysclk = 1'b0;
    logic        reset  = 1'b0;

    logic        fw_req = 0, fw_wr = 0, ua_req = 0, ua_wr = 0;
    logic [7:0]  fw_addr = 0, ua_addr = 0;
    logic [31:0] fw_wdata = 0, ua_wdata = 0, reg_rdata = 0;
    logic        fw_ack, fw_ovf, ua_ack, ua_ovf, reg_wen, owner, busy;
    logic [31:0] fw_rdata, ua_rdata, reg_wdata;
    logic [7:0]  reg_addr;

    logic        d1_fw_req = 0, d1_fw_wr = 0;
    logic [7:0]  d1_fw_addr = 0;
    logic [31:0] d1_fw_wdata = 0, d1_rdata_in = 0;
    logic        d1_fw_ack, d1_fw_ovf, d1_ua_ack, d1_ua_ovf, d1_wen, d1_owner, d1_busy;
    logic [31:0] d1_fw_rdata, d1_ua_rdata, d1_wdata;
    logic [7:0]  d1_addr;

    reg_bus_arbiter #(.RD_LAT(2)) dut (
        .sysclk(sysclk), .reset(reset),
        .fw_req(fw_req), .fw_wr(fw_wr), .fw_addr(fw_addr), .fw_wdata(fw_wdata),
        .fw_ack(fw_ack), .fw_rdata(fw_rdata), .fw_ovf(fw_ovf),
        .ua_req(ua_req), .ua_wr(ua_wr), .ua_addr(ua_addr), .ua_wdata(ua_wdata),
        .ua_ack(ua_ack), .ua_rdata(ua_rdata), .ua_ovf(ua_ovf),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
        .reg_rdata(reg_rdata), .owner(owner), .busy(busy)
    );

    reg_bus_arbiter #(.RD_LAT(1)) dut1 (
        .sysclk(sysclk), .reset(reset),
        .fw_req(d1_fw_req), .fw_wr(d1_fw_wr), .fw_addr(d1_fw_addr), .fw_wdata(d1_fw_wdata),
        .fw_ack(d1_fw_ack), .fw_rdata(d1_fw_rdata), .fw_ovf(d1_fw_ovf),
        .ua_req(1'b0), .ua_wr(1'b0), .ua_addr(8'h00), .ua_wdata(32'h0),
        .ua_ack(d1_ua_ack), .ua_rdata(d1_ua_rdata), .ua_ovf(d1_ua_ovf),
        .reg_addr(d1_addr), .reg_wdata(d1_wdata), .reg_wen(d1_wen),
        .reg_rdata(d1_rdata_in), .owner(d1_owner), .busy(d1_busy)
    );

    always #10 sysclk = ~sysclk;

    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [31:0] rd;
    } exp_t;

    exp_t fw_q[$], ua_q[$], d1_q[$];

    int          wen_cnt = 0, wen_cyc = 0;
    logic [7:0]  wen_addr = 0;
    logic [31:0] wen_data = 0;

    // Output monitor, sampled mid-cycle.
    always @(negedge sysclk) begin
        exp_t e;
        if (reg_wen) begin
            wen_cnt++;
            wen_cyc  = cyc;
            wen_addr = reg_addr;
            wen_data = reg_wdata;
        end
        if (d1_wen) chk("d1_wen_on_read", 32'(d1_wen), 32'h0);
        if (fw_ack) begin
            if (fw_q.size() == 0) chk("fw_ack_unexpected", 32'(fw_ack), 32'h0);
            else begin
                e = fw_q.pop_front();
                chk("fw_ack_cycle", cyc, e.cyc);
                chk("fw_rdata", fw_rdata, e.rd);
                chk("fw_owner", 32'(owner), 32'h0);
            end
        end
        if (ua_ack) begin
            if (ua_q.size() == 0) chk("ua_ack_unexpected", 32'(ua_ack), 32'h0);
            else begin
                e = ua_q.pop_front();
                chk("ua_ack_cycle", cyc, e.cyc);
                chk("ua_rdata", ua_rdata, e.rd);
                chk("ua_owner", 32'(owner), 32'h1);
            end
        end
        if (d1_fw_ack) begin
            if (d1_q.size() == 0) chk("d1_ack_unexpected", 32'(d1_fw_ack), 32'h0);
            else begin
                e = d1_q.pop_front();
                chk("d1_ack_cycle", cyc, e.cyc);
                chk("d1_rdata", d1_fw_rdata, e.rd);
            end
        end
        if (d1_ua_ack) chk("d1_ua_ack_unexpected", 32'(d1_ua_ack), 32'h0);
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
        fw_req    = 1'b0;
        ua_req    = 1'b0;
        d1_fw_req = 1'b0;
    endtask

    task automatic fw_strobe(input logic wr, input logic [7:0] a, input logic [31:0] d);
        fw_req = 1'b1; fw_wr = wr; fw_addr = a; fw_wdata = d;
    endtask

    task automatic ua_strobe(input logic wr, input logic [7:0] a, input logic [31:0] d);
        ua_req = 1'b1; ua_wr = wr; ua_addr = a; ua_wdata = d;
    endtask

    task automatic wait_done();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (fw_q.size() == 0 && ua_q.size() == 0 && d1_q.size() == 0 && !busy && !d1_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk("drain_timeout", 32'(ok), 32'h1);
    endtask

    int c0, w0;

    initial begin
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_fw_ack", 32'(fw_ack), 0);
        chk("rst_ua_ack", 32'(ua_ack), 0);
        chk("rst_fw_ovf", 32'(fw_ovf), 0);
        chk("rst_ua_ovf", 32'(ua_ovf), 0);
        chk("rst_wen", 32'(reg_wen), 0);
        chk("rst_addr", 32'(reg_addr), 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_fw_rdata", fw_rdata, 0);
        chk("rst_ua_rdata", ua_rdata, 0);
        reset = 1'b1;
        tick();

        // Single 1394 write.
        reg_rdata = 32'hA5A5A5A5;
        w0 = wen_cnt; c0 = cyc;
        fw_strobe(1'b1, 8'h08, 32'hDEADBEEF);
        fw_q.push_back('{c0 + 4, 32'h0});
        tick();
        wait_done();
        chk("t1_wen_count", wen_cnt - w0, 1);
        chk("t1_wen_cycle", wen_cyc - c0, 2);
        chk("t1_wen_addr", 32'(wen_addr), 32'h08);
        chk("t1_wen_data", wen_data, 32'hDEADBEEF);
        chk("t1_addr_hold", 32'(reg_addr), 32'h08);
        chk("t1_wdata_hold", reg_wdata, 32'hDEADBEEF);

        // UART read.
        reg_rdata = 32'h12345678;
        w0 = wen_cnt; c0 = cyc;
        ua_strobe(1'b0, 8'h45, 32'h0);
        ua_q.push_back('{c0 + 4, 32'h12345678});
        tick();
        wait_done();
        chk("t2_no_wen", wen_cnt - w0, 0);
        chk("t2_addr_hold", 32'(reg_addr), 32'h45);
        reg_rdata = 32'h0;
        repeat (2) tick();
        chk("t2_rdata_hold", ua_rdata, 32'h12345678);

        // Simultaneous strobes, twice: 1394 wins first, UART second.
        reg_rdata = 32'hCAFE0001;
        c0 = cyc;
        fw_strobe(1'b0, 8'h10, 32'h0);
        ua_strobe(1'b0, 8'h20, 32'h0);
        fw_q.push_back('{c0 + 4, 32'hCAFE0001});
        ua_q.push_back('{c0 + 8, 32'hCAFE0001});
        tick();
        wait_done();
        reg_rdata = 32'hCAFE0002;
        c0 = cyc;
        fw_strobe(1'b0, 8'h10, 32'h0);
        ua_strobe(1'b0, 8'h20, 32'h0);
        ua_q.push_back('{c0 + 4, 32'hCAFE0002});
        fw_q.push_back('{c0 + 8, 32'hCAFE0002});
        tick();
        wait_done();

        // Overflow: two 1394 strobes while a UART transaction holds the bus.
        reg_rdata = 32'h0000BEEF;
        c0 = cyc;
        ua_strobe(1'b0, 8'h30, 32'h0);
        ua_q.push_back('{c0 + 4, 32'h0000BEEF});
        tick();
        tick();
        fw_strobe(1'b1, 8'h31, 32'h11111111);
        fw_q.push_back('{c0 + 8, 32'h0});
        tick();
        fw_strobe(1'b1, 8'h32, 32'h22222222);
        tick();
        chk("t4_fw_ovf_set", 32'(fw_ovf), 1);
        chk("t4_ua_ovf_clear", 32'(ua_ovf), 0);
        wait_done();
        chk("t4_wen_addr", 32'(wen_addr), 32'h31);
        chk("t4_wen_data", wen_data, 32'h11111111);
        repeat (3) tick();
        chk("t4_fw_ovf_sticky", 32'(fw_ovf), 1);

        // Reset while 1394 is in WAIT with UART pending behind it.
        reg_rdata = 32'h00000077;
        c0 = cyc;
        fw_strobe(1'b0, 8'h40, 32'h0);
        tick();
        ua_strobe(1'b0, 8'h41, 32'h0);
        tick();
        tick();
        chk("t5_busy_before", 32'(busy), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t5_busy_after", 32'(busy), 0);
        chk("t5_ovf_cleared", 32'(fw_ovf), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t5_stays_idle", 32'(busy), 0);
        end
        reg_rdata = 32'h00C0FFEE;
        c0 = cyc;
        fw_strobe(1'b0, 8'h42, 32'h0);
        fw_q.push_back('{c0 + 4, 32'h00C0FFEE});
        tick();
        wait_done();

        // RD_LAT = 1 instance: ack one cycle earlier.
        d1_rdata_in = 32'h0BADF00D;
        c0 = cyc;
        d1_fw_req = 1'b1; d1_fw_wr = 1'b0; d1_fw_addr = 8'h05; d1_fw_wdata = 32'h0;
        d1_q.push_back('{c0 + 3, 32'h0BADF00D});
        tick();
        wait_done();
        chk("t6_addr", 32'(d1_addr), 32'h05);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
